// File: rtl/game_table_row_streamer.sv
// Streams changed rows of a 10x10 playfield snapshot to an LCD row writer.
// Keeps a shadow copy of what the LCD shows so unchanged rows are skipped.
//
// state | meaning
// IDLE  | waiting for frame_req
// SCAN  | compare one snapshot row against the shadow copy
// SEND  | row write pending, held until lcd_ready
// DONE  | publish rows_sent, pulse frame_done
module game_table_row_streamer (
    input  logic          clk_40M,
    input  logic          rst,
    input  logic [99:0]   game_table_in,
    input  logic          frame_req,
    input  logic          force_full,
    input  logic          lcd_ready,
    output logic          lcd_valid,
    output logic [3:0]    lcd_row,
    output logic [9:0]    lcd_data,
    output logic          busy,
    output logic          frame_done,
    output logic [3:0]    rows_sent
);

    typedef enum logic [1:0] {IDLE, SCAN, SEND, DONE} state_t;

    state_t          state;
    logic [9:0][9:0] snap;
    logic [9:0][9:0] shadow;
    logic            shadow_inv;
    logic            force_lat;
    logic [3:0]      row;
    logic [3:0]      row_cnt;

    always_ff @(posedge clk_40M or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            snap       <= '0;
            shadow     <= '0;
            shadow_inv <= 1'b1;
            force_lat  <= 1'b0;
            row        <= 4'd0;
            row_cnt    <= 4'd0;
            lcd_valid  <= 1'b0;
            lcd_row    <= 4'd0;
            lcd_data   <= 10'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            rows_sent  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_req) begin
                        snap      <= game_table_in;
                        force_lat <= force_full;
                        row       <= 4'd0;
                        row_cnt   <= 4'd0;
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (force_lat || shadow_inv || (snap[row] != shadow[row])) begin
                        lcd_valid <= 1'b1;
                        lcd_row   <= row;
                        lcd_data  <= snap[row];
                        state     <= SEND;
                    end else if (row == 4'd9) begin
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        row <= row + 4'd1;
                    end
                end
                SEND: begin
                    if (lcd_ready) begin
                        shadow[row] <= snap[row];
                        // at most ten transfers per frame, so this never wraps
                        row_cnt     <= row_cnt + 4'd1;
                        lcd_valid   <= 1'b0;
                        lcd_row     <= 4'd0;
                        lcd_data    <= 10'd0;
                        if (row == 4'd9) begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            row   <= row + 4'd1;
                            state <= SCAN;
                        end
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    rows_sent  <= row_cnt;
                    shadow_inv <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_table_row_streamer.sv
// Directed bench for game_table_row_streamer: full, incremental, idle,
// backpressure, busy-time request and mid-frame reset scenarios.
`timescale 1ns/1ps
module tb_game_table_row_streamer;

    logic        clk_40M = 1'b0;
    logic        rst;
    logic [99:0] game_table_in;
    logic        frame_req;
    logic        force_full;
    logic        lcd_ready;
    logic        lcd_valid;
    logic [3:0]  lcd_row;
    logic [9:0]  lcd_data;
    logic        busy;
    logic        frame_done;
    logic [3:0]  rows_sent;

    int total = 0;
    int bad   = 0;

    int xr [0:15];
    int xd [0:15];

    logic [99:0] t1, t2, t3, t4;
    logic [3:0]  hold_row;
    logic [9:0]  hold_data;
    int n_xfer, done_cyc, first_valid, k;

    game_table_row_streamer dut (
        .clk_40M       (clk_40M),
        .rst           (rst),
        .game_table_in (game_table_in),
        .frame_req     (frame_req),
        .force_full    (force_full),
        .lcd_ready     (lcd_ready),
        .lcd_valid     (lcd_valid),
        .lcd_row       (lcd_row),
        .lcd_data      (lcd_data),
        .busy          (busy),
        .frame_done    (frame_done),
        .rows_sent     (rows_sent)
    );

    always #10 clk_40M = ~clk_40M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_40M);
        #1;
    endtask

    function automatic logic [9:0] row_of(input logic [99:0] t, input int r);
        return t[r*10 +: 10];
    endfunction

    // Pulse frame_req, then watch cycles k=1.. until frame_done, logging transfers.
    task automatic do_frame(input logic frc, input int budget);
        frame_req  = 1'b1;
        force_full = frc;
        step();
        frame_req  = 1'b0;
        force_full = 1'b0;
        n_xfer = 0; done_cyc = -1; first_valid = -1;
        for (int c = 1; c <= budget; c++) begin
            if (lcd_valid && first_valid < 0) first_valid = c;
            if (lcd_valid && lcd_ready && n_xfer < 16) begin
                xr[n_xfer] = int'(lcd_row);
                xd[n_xfer] = int'(lcd_data);
                n_xfer++;
            end
            if (frame_done) begin
                done_cyc = c;
                break;
            end
            step();
        end
        if (done_cyc < 0) chk("frame_timeout", 32'd0, 32'd1);
        step();
    endtask

    initial begin
        rst = 1'b0; game_table_in = '0; frame_req = 1'b0;
        force_full = 1'b0; lcd_ready = 1'b1;

        t1 = {10'h3FF, 10'h0F0, 10'h2AA, 10'h155, 10'h3C0,
              10'h010, 10'h008, 10'h004, 10'h002, 10'h001};
        t2 = t1 ^ (100'd1 << 45);
        t3 = t2 ^ (100'd1 << 70);
        t4 = t3 ^ (100'd1 << 3);

        // reset state
        step(); step();
        chk("rst_valid", 32'(lcd_valid), 32'd0);
        chk("rst_row",   32'(lcd_row),   32'd0);
        chk("rst_data",  32'(lcd_data),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(frame_done),32'd0);
        chk("rst_sent",  32'(rows_sent), 32'd0);
        rst = 1'b1;
        step();

        // post-reset full frame
        game_table_in = t1;
        do_frame(1'b0, 40);
        chk("full_first_valid", 32'(first_valid), 32'd2);
        chk("full_done_cyc",    32'(done_cyc),    32'd21);
        chk("full_nxfer",       32'(n_xfer),      32'd10);
        for (int r = 0; r < 10; r++) begin
            chk("full_row",  32'(xr[r]), 32'(r));
            chk("full_data", 32'(xd[r]), 32'(row_of(t1, r)));
        end
        chk("full_row9",       32'(xd[9]),      32'h3FF);
        chk("full_sent",       32'(rows_sent),  32'd10);
        chk("full_done_1cyc",  32'(frame_done), 32'd0);
        chk("full_idle_busy",  32'(busy),       32'd0);

        // incremental: bit 45 only
        game_table_in = t2;
        do_frame(1'b0, 40);
        chk("inc_nxfer",    32'(n_xfer),   32'd1);
        chk("inc_row",      32'(xr[0]),    32'd4);
        chk("inc_data",     32'(xd[0]),    32'h030);
        chk("inc_done_cyc", 32'(done_cyc), 32'd12);
        chk("inc_sent",     32'(rows_sent),32'd1);

        // no change
        do_frame(1'b0, 40);
        chk("same_valid",    32'(first_valid), 32'hFFFF_FFFF);
        chk("same_done_cyc", 32'(done_cyc),    32'd11);
        chk("same_sent",     32'(rows_sent),   32'd0);

        // backpressure on row 7, table churn during the stall
        game_table_in = t3;
        lcd_ready = 1'b0;
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        k = 1;
        while (!lcd_valid && k < 20) begin step(); k++; end
        chk("bp_first_valid", 32'(k), 32'd9);
        chk("bp_row",  32'(lcd_row),  32'd7);
        chk("bp_data", 32'(lcd_data), 32'(row_of(t3, 7)));
        hold_row = lcd_row; hold_data = lcd_data;
        for (int i = 0; i < 5; i++) begin
            game_table_in = t3 ^ (100'd1 << (80 + i*2)) ^ (100'd1 << 71);
            chk("bp_hold_valid", 32'(lcd_valid), 32'd1);
            chk("bp_hold_row",   32'(lcd_row),   32'(hold_row));
            chk("bp_hold_data",  32'(lcd_data),  32'(hold_data));
            step();
        end
        lcd_ready = 1'b1;
        chk("bp_still_valid", 32'(lcd_valid), 32'd1);
        step();
        chk("bp_released", 32'(lcd_valid), 32'd0);
        chk("bp_idle_row", 32'(lcd_row),   32'd0);
        chk("bp_idle_data",32'(lcd_data),  32'd0);
        n_xfer = 0;
        k = 0;
        while (!frame_done && k < 20) begin
            if (lcd_valid) n_xfer++;
            step(); k++;
        end
        chk("bp_done_seen", 32'(frame_done), 32'd1);
        chk("bp_extra_xfer", 32'(n_xfer), 32'd0);
        step();
        chk("bp_sent", 32'(rows_sent), 32'd1);
        game_table_in = t3;

        // request while busy is dropped, then forced frame
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        step(); step();
        frame_req = 1'b1; force_full = 1'b1;
        step();
        frame_req = 1'b0; force_full = 1'b0;
        n_xfer = 0;
        k = 4;
        while (!frame_done && k < 30) begin
            if (lcd_valid) n_xfer++;
            step(); k++;
        end
        chk("busyreq_done_cyc", 32'(k), 32'd11);
        chk("busyreq_nxfer",    32'(n_xfer), 32'd0);
        step();
        chk("busyreq_sent", 32'(rows_sent), 32'd0);
        step(); step();
        chk("busyreq_not_queued", 32'(busy), 32'd0);
        do_frame(1'b1, 40);
        chk("force_nxfer", 32'(n_xfer),    32'd10);
        chk("force_sent",  32'(rows_sent), 32'd10);

        // reset in stalled SEND
        game_table_in = t4;
        lcd_ready = 1'b0;
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        k = 1;
        while (!lcd_valid && k < 20) begin step(); k++; end
        chk("mid_valid_cyc", 32'(k), 32'd2);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(lcd_valid), 32'd0);
        chk("mid_rst_row",   32'(lcd_row),   32'd0);
        chk("mid_rst_data",  32'(lcd_data),  32'd0);
        chk("mid_rst_busy",  32'(busy),      32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_rst_nodone", 32'(frame_done), 32'd0);
        end
        rst = 1'b1;
        lcd_ready = 1'b1;
        step();
        chk("post_rst_nodone", 32'(frame_done), 32'd0);
        chk("post_rst_idle",   32'(busy),       32'd0);
        do_frame(1'b0, 40);
        chk("post_rst_nxfer", 32'(n_xfer), 32'd10);
        for (int r = 0; r < 10; r++) begin
            chk("post_rst_row",  32'(xr[r]), 32'(r));
            chk("post_rst_data", 32'(xd[r]), 32'(row_of(t4, r)));
        end
        chk("post_rst_sent", 32'(rows_sent), 32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_table_row_streamer.md
GAME_TABLE_ROW_STREAMER -- requirements
Module: game_table_row_streamer

Interface
REQ-001 SHALL have port: clk_40M  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port: game_table_in  input  100  playfield bitmap from the game controller; bit r*10+c = row r (0 top .. 9 bottom), column c (0 left .. 9 right).
REQ-004 SHALL have port: frame_req  input  1  single-cycle pulse requesting a display refresh.
REQ-005 SHALL have port: force_full  input  1  sampled with an accepted frame_req; 1 = send all rows regardless of change.
REQ-006 SHALL have port: lcd_ready  input  1  LCD writer accepts the current row this cycle.
REQ-007 SHALL have port: lcd_valid  output  1  row write pending.
REQ-008 SHALL have port: lcd_row  output  4  row index 0..9 of pending write.
REQ-009 SHALL have port: lcd_data  output  10  cell bits of that row, bit c = column c.
REQ-010 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port: frame_done  output  1  one-cycle pulse at end of frame.
REQ-012 SHALL have port: rows_sent  output  4  number of rows sent in the last completed frame (0..10).

Function
REQ-013 SHALL implement FSM states IDLE, SCAN, SEND, DONE.
REQ-014 In IDLE, frame_req=1 SHALL copy game_table_in into a 100-bit snapshot, latch force_full, clear the row counter and frame row count, and move to SCAN next cycle.
REQ-015 The snapshot SHALL NOT change for the rest of the frame, regardless of game_table_in activity.
REQ-016 frame_req while busy=1 SHALL be ignored (no queuing).
REQ-017 SCAN SHALL examine one row per cycle: if the latched force, shadow-invalid flag, or snapshot row != shadow row, go to SEND; otherwise advance the row, going to DONE after row 9.
REQ-018 In SEND, lcd_valid=1 with lcd_row/lcd_data driven from the snapshot row, held stable until lcd_ready=1 in the same cycle (transfer).
REQ-019 On transfer: shadow row <= snapshot row, frame row count +1, lcd_valid=0 next cycle; after row 9 go to DONE, else return to SCAN at row+1.
REQ-020 lcd_ready while lcd_valid=0 SHALL be ignored.
REQ-021 In DONE: frame_done=1 for exactly one cycle, rows_sent <= frame row count, shadow-invalid flag cleared, return to IDLE next cycle.
REQ-022 Latency: frame_req at cycle N, row 0 changed -> lcd_valid first high in cycle N+2; frame with no changes -> frame_done high in cycle N+11.
REQ-023 lcd_row SHALL be 0 and lcd_data 0 whenever lcd_valid=0.
REQ-024 The row counter SHALL never exceed 9; the frame row count SHALL saturate logic-free at 10 (max possible).

Reset
REQ-025 rst=0 SHALL immediately force: state IDLE, lcd_valid=0, lcd_row=0, lcd_data=0, busy=0, frame_done=0, rows_sent=0, snapshot=0, shadow=0, shadow-invalid flag=1.
REQ-026 Reset mid-frame (including mid-SEND) SHALL abort the frame with no frame_done; the first frame after reset SHALL send all 10 rows.

Verification
REQ-027 Post-reset full frame: frame_req, force_full=0, lcd_ready=1 constant, table with row 9 = 0x3FF -> rows 0..9 sent in order, row 9 data 0x3FF, rows_sent=10, frame_done once.
REQ-028 Incremental update: after REQ-027, flip only bit 45 (row 4, column 5) and request frame -> exactly one transfer, lcd_row=4, lcd_data=0x020 XOR previous row 4, rows_sent=1.
REQ-029 No change: repeat frame_req with identical table -> lcd_valid never high, frame_done at N+11, rows_sent=0.
REQ-030 Backpressure: lcd_ready=0 for 5 cycles during SEND -> lcd_valid, lcd_row, lcd_data stable all 5 cycles; one transfer when lcd_ready rises; table changes during the stall not reflected.
REQ-031 Busy-time request and force: frame_req pulsed while busy -> ignored; next idle frame_req with force_full=1 and unchanged table -> rows_sent=10.
REQ-032 Reset mid-SEND: rst low during stalled SEND -> outputs zero immediately, no frame_done; next frame sends all 10 rows.
